// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained by
// resolved branches, plus saturating branch/mispredict performance counters.
module branch_predictor #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              hit_o,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] pred_target_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_pred_taken_i,
   input  logic [ADDR_W-1:0] upd_pred_target_i,
   output logic              mispredict_o,
   input  logic              inv_i,
   output logic [CNT_W-1:0]  branch_cnt_o,
   output logic [CNT_W-1:0]  mispred_cnt_o
);

   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [CNT_W-1:0]  branch_cnt_q;
   logic [CNT_W-1:0]  mispred_cnt_q;

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic [IDX_W-1:0]  up_idx;
   logic [TAG_W-1:0]  up_tag;
   logic              up_hit;

   assign lk_idx = pc_i[IDX_W+1:2];
   assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
   assign up_idx = upd_pc_i[IDX_W+1:2];
   assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

   // Lookup reads only registered table state, so a same-cycle update to the
   // same index is not visible until the following cycle.
   assign hit_o         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken_o  = hit_o && ctr_q[lk_idx][1];
   assign pred_target_o = hit_o ? target_q[lk_idx] : '0;

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // upd_valid_i qualifies all upd_* fields for exactly one cycle; there is no
   // back-pressure, every presented branch is consumed at the next edge.
   assign mispredict_o = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && upd_pred_taken_i &&
                           (upd_target_i != upd_pred_target_i)));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (inv_i) begin
         // Invalidate wins over any concurrent training; ctr/target are kept.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid_i) begin
         if (up_hit) begin
            if (upd_taken_i) begin
               if (ctr_q[up_idx] != 2'b11) begin
                  ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
               end
               target_q[up_idx] <= upd_target_i;
            end else if (ctr_q[up_idx] != 2'b00) begin
               ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken_i) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
            ctr_q[up_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (upd_valid_i) begin
         if (branch_cnt_q != CNT_MAX) begin
            branch_cnt_q <= branch_cnt_q + CNT_ONE;
         end
         if (mispredict_o && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
         end
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule
